sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/mips_pkg.sv | 28 ++
 rtl/sram_controller.sv | 143 ++++++++++++++
 tb/tb_sram_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory path.
// Holds the SRAM controller state encoding, the data-memory base, and the SRAM widths.
// Pure definitions: no logic, so no latency or backpressure of its own.
package mips_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_ADDR_W = SRAM_ADDR_W - 1;
    localparam int CPU_DATA_W  = 32;

    localparam logic [31:0] DATA_MEM_BASE_DEF = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } sram_state_e;

    // Byte address -> 32-bit word index inside the SRAM, wrapping modulo 2^17 words.
    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr,
                                                         input logic [31:0] base);
        logic [31:0] offset;
        offset = byte_addr - base;
        return offset[WORD_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM, done as two half-word accesses.
// Latency: 2*WAIT_CYCLES+3 cycles with ready low, then one DONE cycle with ready high.
// Backpressure: ready drops in the request cycle and stays low until DONE; the pipeline freezes on ~ready.
module sram_controller
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            ALU_res,
    input  logic [31:0]            ST_value,
    output logic [CPU_DATA_W-1:0]  readData,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
    output logic                   SRAM_DQ_oe,
    output logic                   SRAM_WE_N
);

    // Last count value of a half-access phase (phase lasts WAIT_CYCLES+1 cycles).
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    sram_state_e            state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic [WORD_ADDR_W-1:0] word_q, word_d;
    logic [CPU_DATA_W-1:0]  st_val_q, st_val_d;
    logic [CPU_DATA_W-1:0]  read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic                   req;

    assign req = MEM_R_EN | MEM_W_EN;

    // Next-state, latch and read-capture logic; SRAM strobes are precomputed from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        st_val_d    = st_val_q;
        read_data_d = read_data_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = ACC_LO;
                    cnt_d    = 3'd0;
                    // A simultaneous read+write request is served as a write.
                    is_wr_d  = MEM_W_EN;
                    word_d   = word_addr(ALU_res, DATA_MEM_BASE);
                    st_val_d = ST_value;
                end
            end
            ACC_LO: begin
                if (cnt_q == LAST_CNT) begin
                    if (!is_wr_q) read_data_d[15:0] = SRAM_DQ_in;
                    state_d = ACC_HI;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACC_HI: begin
                if (cnt_q == LAST_CNT) begin
                    if (!is_wr_q) read_data_d[31:16] = SRAM_DQ_in;
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        sram_addr_d = '0;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        if (state_d == ACC_LO) begin
            sram_addr_d = {word_d, 1'b0};
            if (is_wr_d) begin
                dq_out_d = st_val_d[15:0];
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
            end
        end else if (state_d == ACC_HI) begin
            sram_addr_d = {word_d, 1'b1};
            if (is_wr_d) begin
                dq_out_d = st_val_d[31:16];
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
            end
        end
    end

    // FSM and registered SRAM-side outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            st_val_q    <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            st_val_q    <= st_val_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign readData    = read_data_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_DQ_out = dq_out_q;
    // Reset suppresses the strobe in the very cycle it is asserted, so an aborted
    // access never lands one more half-word at the edge where reset is taken.
    assign SRAM_WE_N   = we_n_q | rst;
    assign SRAM_DQ_oe  = dq_oe_q & ~rst;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES=1 and 0), each on its own behavioural SRAM.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units after it.
// Expected data comes from a word-level memory model and the access-length formula.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 1: WAIT_CYCLES = 1
    logic        r_en1 = 0, w_en1 = 0;
    logic [31:0] alu1 = 0, st1 = 0, rd1;
    logic        rdy1, oe1, wen1;
    logic [17:0] addr1;
    logic [15:0] dqo1, dqi1;
    logic [15:0] sram1 [0:262143];

    // Instance 0: WAIT_CYCLES = 0
    logic        r_en0 = 0, w_en0 = 0;
    logic [31:0] alu0 = 0, st0 = 0, rd0;
    logic        rdy0, oe0, wen0;
    logic [17:0] addr0;
    logic [15:0] dqo0, dqi0;
    logic [15:0] sram0 [0:262143];

    sram_controller #(.WAIT_CYCLES(1), .DATA_MEM_BASE(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en1), .MEM_W_EN(w_en1), .ALU_res(alu1),
        .ST_value(st1), .readData(rd1), .ready(rdy1), .SRAM_ADDR(addr1),
        .SRAM_DQ_out(dqo1), .SRAM_DQ_in(dqi1), .SRAM_DQ_oe(oe1), .SRAM_WE_N(wen1));

    sram_controller #(.WAIT_CYCLES(0), .DATA_MEM_BASE(32'd1024)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0), .ALU_res(alu0),
        .ST_value(st0), .readData(rd0), .ready(rdy0), .SRAM_ADDR(addr0),
        .SRAM_DQ_out(dqo0), .SRAM_DQ_in(dqi0), .SRAM_DQ_oe(oe0), .SRAM_WE_N(wen0));

    // Behavioural 256K x 16 SRAMs: write when WE_N low at the clock edge, combinational read.
    always @(posedge clk) if (wen1 === 1'b0) sram1[addr1] <= dqo1;
    always @(posedge clk) if (wen0 === 1'b0) sram0[addr0] <= dqo0;
    assign dqi1 = sram1[addr1];
    assign dqi0 = sram0[addr0];

    // Reference model: 32-bit words indexed by word address, plus expected readData.
    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_rd = 32'd0;

    function automatic int unsigned wordof(input logic [31:0] a);
        logic [31:0] o;
        o = (a - 32'd1024) >> 2;
        return int'(o & 32'h0001_FFFF);
    endfunction

    function automatic logic [17:0] half_idx(input int unsigned w, input bit hi);
        logic [31:0] t;
        t = w * 2 + (hi ? 1 : 0);
        return t[17:0];
    endfunction

    // One access on instance 1; returns the ready-low span and readData seen in the DONE cycle.
    task automatic do_access1(input logic re, input logic we, input logic [31:0] a,
                              input logic [31:0] d, output int span, output logic [31:0] rd);
        @(posedge clk); #1;
        r_en1 = re; w_en1 = we; alu1 = a; st1 = d;
        #1;
        span = 0;
        while (rdy1 !== 1'b1 && span < 40) begin
            span++;
            @(posedge clk); #1;
            r_en1 = 0; w_en1 = 0; alu1 = $urandom; st1 = $urandom;
            #1;
        end
        rd = rd1;
        if (span >= 40) begin
            n_cmp++; n_err++;
            $display("FAIL access_timeout1: ready never returned after %0d cycles", span);
        end
    endtask

    task automatic check_span1(input string name, input int span);
        n_cmp++;
        if (span !== 5) begin
            n_err++;
            $display("FAIL %s_span: got %0d ready-low cycles, expected 5", name, span);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", rdy1); end
        n_cmp++; if (wen1 !== 1'b1) begin n_err++; $display("FAIL reset_we_n: got %b expected 1", wen1); end
        n_cmp++; if (oe1 !== 1'b0)  begin n_err++; $display("FAIL reset_oe: got %b expected 0", oe1); end
        n_cmp++; if (addr1 !== 18'd0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", addr1); end
        n_cmp++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL reset_readData: got %h expected 0", rd1); end
        n_cmp++; if (rd0 !== 32'd0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_dut0: rd=%h rdy=%b expected 0/1", rd0, rdy0); end
        rst = 1'b0;
        exp_rd = 32'd0;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            n_cmp++;
            if (rdy1 !== 1'b1 || wen1 !== 1'b1 || oe1 !== 1'b0) begin
                n_err++;
                $display("FAIL idle_c%0d: ready=%b we_n=%b oe=%b expected 1/1/0", c, rdy1, wen1, oe1);
            end
        end
    endtask

    task automatic test_store;
        int span; logic [31:0] rd;
        do_access1(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, span, rd);
        check_span1("store", span);
        model_mem[wordof(32'd1028)] = 32'hDEADBEEF;
        n_cmp++; if (sram1[2] !== 16'hBEEF) begin n_err++; $display("FAIL store_lo: SRAM[2]=%h expected beef", sram1[2]); end
        n_cmp++; if (sram1[3] !== 16'hDEAD) begin n_err++; $display("FAIL store_hi: SRAM[3]=%h expected dead", sram1[3]); end
        n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL store_rd_kept: got %h expected %h", rd, exp_rd); end
    endtask

    task automatic test_load;
        int span; logic [31:0] rd;
        do_access1(1'b1, 1'b0, 32'd1028, 32'h0, span, rd);
        check_span1("load", span);
        exp_rd = model_mem[wordof(32'd1028)];
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            n_cmp++;
            if (rd1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_hold_c%0d: got %h expected deadbeef", c, rd1); end
        end
    endtask

    task automatic test_both_enables;
        int span; logic [31:0] rd;
        do_access1(1'b1, 1'b1, 32'd1024, 32'h12345678, span, rd);
        check_span1("both", span);
        model_mem[0] = 32'h12345678;
        n_cmp++; if (sram1[0] !== 16'h5678) begin n_err++; $display("FAIL both_lo: SRAM[0]=%h expected 5678", sram1[0]); end
        n_cmp++; if (sram1[1] !== 16'h1234) begin n_err++; $display("FAIL both_hi: SRAM[1]=%h expected 1234", sram1[1]); end
        n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL both_rd_kept: got %h expected %h", rd, exp_rd); end
    endtask

    // Addresses below the data-memory base wrap to the top of the SRAM.
    task automatic test_wrap;
        int span; logic [31:0] rd, d, a;
        int unsigned w;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'd0 : 32'd1023;
            w = wordof(a);
            d = $urandom;
            do_access1(1'b0, 1'b1, a, d, span, rd);
            check_span1("wrap_store", span);
            model_mem[w] = d;
            n_cmp++;
            if ({sram1[half_idx(w, 1)], sram1[half_idx(w, 0)]} !== d) begin
                n_err++;
                $display("FAIL wrap_store_%0d: SRAM word %h = %h%h expected %h", k, w,
                         sram1[half_idx(w, 1)], sram1[half_idx(w, 0)], d);
            end
            do_access1(1'b1, 1'b0, a, 32'h0, span, rd);
            check_span1("wrap_load", span);
            exp_rd = d;
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL wrap_load_%0d: got %h expected %h", k, rd, exp_rd); end
        end
    endtask

    task automatic test_random;
        int span; logic [31:0] rd, d, a;
        int unsigned w, kind;
        for (int i = 0; i < 56; i++) begin
            w    = (i < 16) ? i : $urandom_range(0, 15);
            kind = (i < 16) ? 1 : $urandom_range(0, 2);
            a    = 32'd1024 + w * 4 + $urandom_range(0, 3);
            d    = $urandom;
            do_access1(kind != 1, kind != 0, a, d, span, rd);
            check_span1("rand", span);
            if (kind == 0) begin
                exp_rd = model_mem[w];
            end else begin
                model_mem[w] = d;
                n_cmp++;
                if ({sram1[half_idx(w, 1)], sram1[half_idx(w, 0)]} !== d) begin
                    n_err++;
                    $display("FAIL rand_wr_%0d: word %0d = %h%h expected %h", i, w,
                             sram1[half_idx(w, 1)], sram1[half_idx(w, 0)], d);
                end
            end
            n_cmp++;
            if (rd !== exp_rd) begin n_err++; $display("FAIL rand_rd_%0d: got %h expected %h", i, rd, exp_rd); end
        end
    endtask

    task automatic test_reset_mid_access;
        logic [15:0] hi_before;
        hi_before = sram1[1];
        @(posedge clk); #1;
        w_en1 = 1'b1; alu1 = 32'd1024; st1 = 32'hCAFEF00D;
        @(posedge clk); #1; w_en1 = 1'b0;        // ACC_LO, 1st cycle
        @(posedge clk); #1;                      // ACC_LO, 2nd cycle
        @(posedge clk); #1;                      // ACC_HI, 1st cycle
        n_cmp++; if (addr1 !== 18'd1) begin n_err++; $display("FAIL rstmid_in_hi: SRAM_ADDR=%h expected 1", addr1); end
        rst = 1'b1;
        #1;
        n_cmp++; if (wen1 !== 1'b1) begin n_err++; $display("FAIL rstmid_strobe_cut: we_n=%b expected 1", wen1); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_rd = 32'd0;
        n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", rdy1); end
        n_cmp++; if (wen1 !== 1'b1 || oe1 !== 1'b0) begin n_err++; $display("FAIL rstmid_strobes: we_n=%b oe=%b expected 1/0", wen1, oe1); end
        n_cmp++; if (rd1 !== exp_rd) begin n_err++; $display("FAIL rstmid_readData: got %h expected 0", rd1); end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (sram1[1] !== hi_before) begin n_err++; $display("FAIL rstmid_hi_untouched: SRAM[1]=%h expected %h", sram1[1], hi_before); end
        n_cmp++; if (wen1 !== 1'b1 || rdy1 !== 1'b1) begin n_err++; $display("FAIL rstmid_stays_idle: we_n=%b ready=%b", wen1, rdy1); end
    endtask

    // WAIT_CYCLES=0: seed two words, then two loads with the request held so the second follows DONE directly.
    task automatic test_back_to_back;
        logic [31:0] v [2];
        int cnt;
        for (int k = 0; k < 2; k++) begin
            v[k] = $urandom;
            @(posedge clk); #1;
            w_en0 = 1'b1; alu0 = 32'd1024 + k * 4; st0 = v[k];
            @(posedge clk); #1; w_en0 = 1'b0;
            cnt = 0;
            #1;
            while (rdy0 !== 1'b1 && cnt < 20) begin cnt++; @(posedge clk); #2; end
            n_cmp++;
            if (cnt !== 2) begin n_err++; $display("FAIL b2b_seed%0d: %0d cycles to DONE, expected 2", k, cnt); end
        end
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            logic        e_rdy;
            logic [17:0] e_addr;
            @(posedge clk); #1;
            r_en0 = (c < 7);
            alu0  = (c < 4) ? 32'd1024 : 32'd1028;
            #1;
            e_rdy = (c == 3 || c == 7);
            case (c)
                1: e_addr = 18'd0;
                2: e_addr = 18'd1;
                5: e_addr = 18'd2;
                6: e_addr = 18'd3;
                default: e_addr = 18'd0;
            endcase
            n_cmp++;
            if (rdy0 !== e_rdy || addr0 !== e_addr) begin
                n_err++;
                $display("FAIL b2b_c%0d: ready=%b addr=%h expected %b/%h", c, rdy0, addr0, e_rdy, e_addr);
            end
            if (c == 3 || c == 7) begin
                n_cmp++;
                if (rd0 !== v[c / 4]) begin n_err++; $display("FAIL b2b_data_c%0d: got %h expected %h", c, rd0, v[c / 4]); end
            end
        end
        r_en0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_store();
        test_load();
        test_both_enables();
        test_wrap();
        test_random();
        test_reset_mid_access();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
